flush_bit_array: RTL and testbench

FLUSH_BIT_ARRAY -- requirements
Module: flush_bit_array

---
 rtl/flush_bit_array.sv | 128 ++++++++++++
 tb/tb_flush_bit_array.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flush_bit_array.sv
// flush_bit_array: DEPTH x WIDTH flag storage with flash clear and
// a masked scan engine that reports and optionally clears set entries.
module flush_bit_array #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            write,
   input  logic [IDXW-1:0]  index,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] dataout,
   input  logic            clear_all,
   input  logic            scan_start,
   input  logic [WIDTH-1:0] scan_mask,
   input  logic            scan_ready,
   input  logic            scan_clear,
   output logic            scan_busy,
   output logic            scan_valid,
   output logic [IDXW-1:0]  scan_index,
   output logic [WIDTH-1:0] scan_data,
   output logic            scan_done
);

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      REPORT,
      DONE
   } state_e;

   state_e state_q, state_d;

   logic [IDXW-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0] mask_q, mask_d;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

   logic hit;
   logic last;
   logic hs;

   assign hit  = |(mem_q[ptr_q] & mask_q);
   assign last = (ptr_q == IDXW'(DEPTH - 1));
   assign hs   = (state_q == REPORT) && scan_ready;

   assign dataout    = mem_q[index];
   assign scan_data  = mem_q[ptr_q];
   assign scan_index = ptr_q;
   assign scan_busy  = (state_q != IDLE);
   assign scan_valid = (state_q == REPORT);
   assign scan_done  = (state_q == DONE);

   // Scan sequencing: walk entries, stop on hits, one-cycle DONE.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mask_d  = mask_q;
      unique case (state_q)
         IDLE: begin
            ptr_d = '0;
            if (scan_start) begin
               mask_d  = scan_mask;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (hit) begin
               state_d = REPORT;
            end else if (last) begin
               state_d = DONE;
            end else begin
               ptr_d = ptr_q + IDXW'(1);
            end
         end
         REPORT: begin
            if (scan_ready) begin
               if (last) begin
                  state_d = DONE;
               end else begin
                  ptr_d   = ptr_q + IDXW'(1);
                  state_d = SEARCH;
               end
            end
         end
         DONE: begin
            ptr_d   = '0;
            state_d = IDLE;
         end
         default: begin
            ptr_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Storage update: flash clear beats write, write beats scan clear.
   always_comb begin
      mem_d = mem_q;
      if (clear_all) begin
         mem_d = '0;
      end else begin
         if (hs && scan_clear) begin
            mem_d[ptr_q] = mem_q[ptr_q] & ~mask_q;
         end
         if (write) begin
            mem_d[index] = datain;
         end
      end
   end

   // State, pointer, mask and storage registers with sync reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         mask_q  <= '0;
         mem_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mask_q  <= mask_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: tb/tb_flush_bit_array.sv
// tb_flush_bit_array: scenario tasks with a queue scoreboard of the
// entries each scan is expected to report.
module tb_flush_bit_array;

   localparam int WIDTH = 2;
   localparam int DEPTH = 8;
   localparam int IDXW  = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            write;
   logic [IDXW-1:0]  index;
   logic [WIDTH-1:0] datain;
   logic [WIDTH-1:0] dataout;
   logic            clear_all;
   logic            scan_start;
   logic [WIDTH-1:0] scan_mask;
   logic            scan_ready;
   logic            scan_clear;
   logic            scan_busy;
   logic            scan_valid;
   logic [IDXW-1:0]  scan_index;
   logic [WIDTH-1:0] scan_data;
   logic            scan_done;

   int errors = 0;
   int checks = 0;

   logic [IDXW-1:0]  exp_idx[$];
   logic [WIDTH-1:0] exp_dat[$];

   always #5 clk = ~clk;

   flush_bit_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .index      (index),
      .datain     (datain),
      .dataout    (dataout),
      .clear_all  (clear_all),
      .scan_start (scan_start),
      .scan_mask  (scan_mask),
      .scan_ready (scan_ready),
      .scan_clear (scan_clear),
      .scan_busy  (scan_busy),
      .scan_valid (scan_valid),
      .scan_index (scan_index),
      .scan_data  (scan_data),
      .scan_done  (scan_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      write      = 1'b0;
      index      = '0;
      datain     = '0;
      clear_all  = 1'b0;
      scan_start = 1'b0;
      scan_mask  = '0;
      scan_ready = 1'b0;
      scan_clear = 1'b0;
      tick();
      reset = 1'b0;
      exp_idx.delete();
      exp_dat.delete();
   endtask

   task automatic wr(input int i, input logic [WIDTH-1:0] d);
      write  = 1'b1;
      index  = IDXW'(i);
      datain = d;
      tick();
      write = 1'b0;
   endtask

   // Run a scan to completion, popping the scoreboard on each report.
   task automatic run_scan(input string name, input logic [WIDTH-1:0] m);
      logic seen_done;
      seen_done  = 1'b0;
      scan_mask  = m;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      scan_mask  = ~m;
      for (int n = 0; n < 40; n++) begin
         if (scan_valid) begin
            checks++;
            if (exp_idx.size() == 0) begin
               errors++;
               $display("FAIL %s extra_valid idx=%0d expected none",
                        name, scan_index);
            end else begin
               logic [IDXW-1:0]  ei;
               logic [WIDTH-1:0] ed;
               ei = exp_idx.pop_front();
               ed = exp_dat.pop_front();
               if (scan_index !== ei || scan_data !== ed) begin
                  errors++;
                  $display("FAIL %s report got=%0d/%b exp=%0d/%b",
                           name, scan_index, scan_data, ei, ed);
               end
            end
         end
         if (scan_done) begin
            seen_done = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!seen_done || exp_idx.size() != 0) begin
         errors++;
         $display("FAIL %s completion done=%0b left=%0d exp done=1 left=0",
                  name, seen_done, exp_idx.size());
      end
      tick();
   endtask

   task automatic wait_valid(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (scan_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      write      = 1'b1;
      index      = 3'd2;
      datain     = 2'b11;
      clear_all  = 1'b0;
      scan_start = 1'b1;
      scan_mask  = 2'b11;
      scan_ready = 1'b0;
      scan_clear = 1'b0;
      tick();
      reset      = 1'b0;
      write      = 1'b0;
      scan_start = 1'b0;
      checks++;
      if ({scan_busy, scan_valid, scan_done} !== 3'b000 ||
          scan_index !== 3'd0 || scan_data !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs got=%b/%0d/%b exp=000/0/00",
                  {scan_busy, scan_valid, scan_done}, scan_index, scan_data);
      end
      for (int i = 0; i < DEPTH; i++) begin
         index = IDXW'(i);
         #1;
         checks++;
         if (dataout !== 2'b00) begin
            errors++;
            $display("FAIL reset_entry%0d got=%b exp=00", i, dataout);
         end
      end
   endtask

   task automatic test_basic();
      do_reset();
      wr(3, 2'b10);
      wr(6, 2'b11);
      exp_idx.push_back(3'd3);
      exp_dat.push_back(2'b10);
      exp_idx.push_back(3'd6);
      exp_dat.push_back(2'b11);
      scan_ready = 1'b1;
      scan_clear = 1'b1;
      run_scan("basic", 2'b10);
      scan_clear = 1'b0;
      index = 3'd3;
      #1;
      checks++;
      if (dataout !== 2'b00) begin
         errors++;
         $display("FAIL basic_clear3 got=%b exp=00", dataout);
      end
      index = 3'd6;
      #1;
      checks++;
      if (dataout !== 2'b01) begin
         errors++;
         $display("FAIL basic_clear6 got=%b exp=01", dataout);
      end
   endtask

   task automatic test_empty();
      do_reset();
      scan_ready = 1'b1;
      scan_mask  = 2'b11;
      scan_start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         scan_start = 1'b0;
         checks++;
         if (scan_done !== (c == 9) || scan_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_c%0d done=%b valid=%b exp done=%0b valid=0",
                     c, scan_done, scan_valid, (c == 9));
         end
      end
   endtask

   task automatic test_mask_zero();
      do_reset();
      for (int i = 0; i < DEPTH; i++) wr(i, 2'b11);
      scan_ready = 1'b1;
      run_scan("mask_zero", 2'b00);
   endtask

   task automatic test_stall();
      logic ok;
      do_reset();
      wr(2, 2'b01);
      scan_ready = 1'b0;
      scan_mask  = 2'b01;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok || scan_index !== 3'd2) begin
         errors++;
         $display("FAIL stall_first ok=%b idx=%0d exp ok=1 idx=2",
                  ok, scan_index);
      end
      for (int s = 0; s < 5; s++) begin
         checks++;
         if (scan_valid !== 1'b1 || scan_index !== 3'd2) begin
            errors++;
            $display("FAIL stall_hold%0d valid=%b idx=%0d exp 1/2",
                     s, scan_valid, scan_index);
         end
         tick();
      end
      scan_ready = 1'b1;
      tick();
      checks++;
      if (scan_valid !== 1'b0 || scan_index !== 3'd3) begin
         errors++;
         $display("FAIL stall_advance valid=%b idx=%0d exp 0/3",
                  scan_valid, scan_index);
      end
      for (int n = 0; n < 12 && !scan_done; n++) tick();
      tick();
   endtask

   task automatic test_write_wins();
      logic ok;
      do_reset();
      wr(4, 2'b01);
      scan_ready = 1'b0;
      scan_clear = 1'b1;
      scan_mask  = 2'b01;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok || scan_index !== 3'd4) begin
         errors++;
         $display("FAIL wwin_report ok=%b idx=%0d exp ok=1 idx=4",
                  ok, scan_index);
      end
      write      = 1'b1;
      index      = 3'd4;
      datain     = 2'b11;
      scan_ready = 1'b1;
      tick();
      write      = 1'b0;
      scan_clear = 1'b0;
      index      = 3'd4;
      #1;
      checks++;
      if (dataout !== 2'b11) begin
         errors++;
         $display("FAIL wwin_data got=%b exp=11", dataout);
      end
      for (int n = 0; n < 12 && !scan_done; n++) tick();
      tick();
   endtask

   task automatic test_clear_all();
      logic vseen;
      logic dseen;
      vseen = 1'b0;
      dseen = 1'b0;
      do_reset();
      wr(5, 2'b01);
      scan_ready = 1'b1;
      scan_mask  = 2'b01;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick();
      checks++;
      if (scan_index !== 3'd1 || scan_valid !== 1'b0) begin
         errors++;
         $display("FAIL clrall_ptr idx=%0d exp=1", scan_index);
      end
      clear_all = 1'b1;
      tick();
      clear_all = 1'b0;
      for (int n = 0; n < 15; n++) begin
         if (scan_valid) vseen = 1'b1;
         if (scan_done) begin
            dseen = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (vseen !== 1'b0 || dseen !== 1'b1) begin
         errors++;
         $display("FAIL clrall_scan valid_seen=%b done_seen=%b exp 0/1",
                  vseen, dseen);
      end
      tick();
   endtask

   task automatic test_reset_in_report();
      logic ok;
      logic dseen;
      dseen = 1'b0;
      do_reset();
      wr(2, 2'b11);
      scan_ready = 1'b0;
      scan_mask  = 2'b11;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      wait_valid(ok);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      index = 3'd2;
      #1;
      checks++;
      if (!ok || {scan_busy, scan_valid, scan_done} !== 3'b000 ||
          dataout !== 2'b00) begin
         errors++;
         $display("FAIL rst_report ok=%b st=%b d=%b exp ok=1 st=000 d=00",
                  ok, {scan_busy, scan_valid, scan_done}, dataout);
      end
      for (int n = 0; n < 12; n++) begin
         if (scan_done) dseen = 1'b1;
         tick();
      end
      checks++;
      if (dseen !== 1'b0) begin
         errors++;
         $display("FAIL rst_nodone got=%b exp=0", dseen);
      end
      wr(1, 2'b01);
      exp_idx.push_back(3'd1);
      exp_dat.push_back(2'b01);
      scan_ready = 1'b1;
      run_scan("rst_rescan", 2'b01);
   endtask

   task automatic test_back_to_back();
      do_reset();
      wr(0, 2'b10);
      wr(7, 2'b10);
      scan_ready = 1'b1;
      scan_clear = 1'b0;
      for (int r = 0; r < 2; r++) begin
         exp_idx.push_back(3'd0);
         exp_dat.push_back(2'b10);
         exp_idx.push_back(3'd7);
         exp_dat.push_back(2'b10);
         run_scan("b2b", 2'b10);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_mask_zero();
      test_stall();
      test_write_wins();
      test_clear_all();
      test_reset_in_report();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
